ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage scalar core; the direct consumer of the forwarding unit's forward_a/forward_b selects.
- Resolves rs1/rs2 operands from the register-file read, the MEM-stage result or the WB-stage result, then runs the ALU.
- Registers the result, store data and control into the EX/MEM pipeline register.
- Honours stall (hold) and flush (bubble) from the hazard/branch logic.

Parameters:
DATA_WIDTH, 32, operand/result width; shift amount uses low $clog2(DATA_WIDTH) bits of operand B
NOP_INSTR, 32'h0000_0013, instruction word recorded for bubbles

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID/EX holds a real instruction
id_rs1_data  input  DATA_WIDTH  rs1 value read from register file
id_rs2_data  input  DATA_WIDTH  rs2 value read from register file
id_imm  input  DATA_WIDTH  sign-extended immediate
id_pc  input  DATA_WIDTH  instruction PC
id_alu_op  input  4  ALU operation code (see Behaviour)
id_alu_src_imm  input  1  1: operand B = id_imm; 0: forwarded rs2
id_is_store  input  1  instruction is a store
id_reg_write  input  1  instruction writes rd
id_rd_addr  input  5  destination register
id_instr  input  32  raw instruction word (debug tracking)
forward_a  input  2  rs1 source select from forwarding unit
forward_b  input  2  rs2 source select from forwarding unit
mem_fwd_data  input  DATA_WIDTH  result currently in MEM stage
wb_fwd_data  input  DATA_WIDTH  result currently in WB stage
stall  input  1  hold EX/MEM register contents
flush  input  1  load a bubble into EX/MEM
ex_mem_valid  output  1  EX/MEM holds a real instruction
ex_mem_alu_result  output  DATA_WIDTH  registered ALU result
ex_mem_store_data  output  DATA_WIDTH  registered forwarded rs2 (store data)
ex_mem_rd_addr  output  5  registered destination
ex_mem_reg_write  output  1  registered write enable
ex_mem_is_store  output  1  registered store flag
ex_mem_instr  output  32  registered instruction word

Behaviour:
- Operand select (combinational), same for A (rs1) and B (rs2):
  - 00: register-file value
  - 01: wb_fwd_data
  - 10: mem_fwd_data
  - 11: reserved; treated as 00
- Operand B = id_imm when id_alu_src_imm=1, else forwarded rs2.
- Store data is always forwarded rs2, independent of id_alu_src_imm.
- id_alu_op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed, result 1/0), 4 SLTU, 5 XOR
  - 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 PASS_B (LUI), 11 PC+B (AUIPC/JAL link base)
  - 12-15: result 0
- Arithmetic wraps modulo 2^DATA_WIDTH; no overflow flag.
- Latency: one cycle; ID/EX inputs at edge N appear on ex_mem_* after edge N.
- Register update priority per rising edge:
  1. flush=1: bubble. valid=0, reg_write=0, is_store=0, rd_addr=0, alu_result=0, store_data=0, instr=NOP_INSTR. Flush wins over stall.
  2. stall=1 (flush=0): all ex_mem_* hold their values.
  3. Otherwise, id_valid=0: load the bubble values above.
  4. Otherwise: load computed values; valid=1, reg_write/is_store/rd_addr/instr copied from ID.
- Reset (async assert, any time including mid-stall): all ex_mem_* take bubble values immediately, without waiting for a clock edge. Reset release takes effect at the next edge.
- rd_addr=0 with reg_write=1 is passed through unmodified; x0 suppression belongs to the forwarding unit and the register file.
- No internal state other than the EX/MEM register.

Test Plan:
- Reset: assert rst mid-cycle with outputs non-zero -> ex_mem_valid=0, ex_mem_instr=0x00000013, all other outputs 0 before the next edge.
- Forward select: rs1_data=5, mem_fwd=100, wb_fwd=200, rs2_data=7, ADD, no imm:
  - forward_a=00 -> result 12; 01 -> 207; 10 -> 107; 11 -> 12
  - forward_b=10 with forward_a=00 -> 105
- Store data: is_store=1, alu_src_imm=1, imm=8, rs1=0x1000, forward_b=01, wb_fwd=0xDEADBEEF -> ex_mem_alu_result=0x1008, ex_mem_store_data=0xDEADBEEF, ex_mem_is_store=1.
- ALU edges:
  - SUB 0-1 -> 0xFFFFFFFF
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0
  - SRA 0x80000000 by B=0x24 (shift 4) -> 0xF8000000
  - SRL same -> 0x08000000
  - op 13 -> 0
- Stall/flush: load ADD result 3, then 2 cycles stall=1 with new inputs -> outputs hold 3.
  - stall=1 and flush=1 together -> bubble.
  - Next cycle stall=0 with id_valid=0 -> bubble persists.
- Back-to-back: 4 consecutive valid instructions (AUIPC pc=0x40, imm=0x1000 -> 0x1040; LUI -> imm; XOR; AND) -> one result per cycle, each one cycle after its inputs, instr words tracked in order.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: resolves forwarded operands, runs the ALU and loads the EX/MEM
// pipeline register, honouring stall (hold) and flush (bubble).
module ex_stage #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [3:0]            id_alu_op,
    input  logic                  id_alu_src_imm,
    input  logic                  id_is_store,
    input  logic                  id_reg_write,
    input  logic [4:0]            id_rd_addr,
    input  logic [31:0]           id_instr,
    input  logic [1:0]            forward_a,
    input  logic [1:0]            forward_b,
    input  logic [DATA_WIDTH-1:0] mem_fwd_data,
    input  logic [DATA_WIDTH-1:0] wb_fwd_data,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  ex_mem_valid,
    output logic [DATA_WIDTH-1:0] ex_mem_alu_result,
    output logic [DATA_WIDTH-1:0] ex_mem_store_data,
    output logic [4:0]            ex_mem_rd_addr,
    output logic                  ex_mem_reg_write,
    output logic                  ex_mem_is_store,
    output logic [31:0]           ex_mem_instr
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] op_a_s;
    logic [DATA_WIDTH-1:0] rs2_fwd_s;
    logic [DATA_WIDTH-1:0] op_b_s;
    logic [SHW-1:0]        shamt_s;
    logic [DATA_WIDTH-1:0] alu_res_s;

    logic                  valid_d,      valid_q;
    logic [DATA_WIDTH-1:0] alu_result_d, alu_result_q;
    logic [DATA_WIDTH-1:0] store_data_d, store_data_q;
    logic [4:0]            rd_addr_d,    rd_addr_q;
    logic                  reg_write_d,  reg_write_q;
    logic                  is_store_d,   is_store_q;
    logic [31:0]           instr_d,      instr_q;

    // Operand resolution; the reserved select 2'b11 falls back to the register file
    always_comb begin
        case (forward_a)
            2'b01:   op_a_s = wb_fwd_data;
            2'b10:   op_a_s = mem_fwd_data;
            default: op_a_s = id_rs1_data;
        endcase
        case (forward_b)
            2'b01:   rs2_fwd_s = wb_fwd_data;
            2'b10:   rs2_fwd_s = mem_fwd_data;
            default: rs2_fwd_s = id_rs2_data;
        endcase
        if (id_alu_src_imm) begin
            op_b_s = id_imm;
        end else begin
            op_b_s = rs2_fwd_s;
        end
        shamt_s = op_b_s[SHW-1:0];
    end

    // ALU
    always_comb begin
        case (id_alu_op)
            4'd0:    alu_res_s = op_a_s + op_b_s;
            4'd1:    alu_res_s = op_a_s - op_b_s;
            4'd2:    alu_res_s = op_a_s << shamt_s;
            4'd3:    alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
            4'd4:    alu_res_s = {{(DATA_WIDTH-1){1'b0}}, (op_a_s < op_b_s)};
            4'd5:    alu_res_s = op_a_s ^ op_b_s;
            4'd6:    alu_res_s = op_a_s >> shamt_s;
            4'd7:    alu_res_s = $signed(op_a_s) >>> shamt_s;
            4'd8:    alu_res_s = op_a_s | op_b_s;
            4'd9:    alu_res_s = op_a_s & op_b_s;
            4'd10:   alu_res_s = op_b_s;
            4'd11:   alu_res_s = id_pc + op_b_s;
            default: alu_res_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // EX/MEM next state: flush beats stall, stall beats loading
    always_comb begin
        valid_d      = valid_q;
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        rd_addr_d    = rd_addr_q;
        reg_write_d  = reg_write_q;
        is_store_d   = is_store_q;
        instr_d      = instr_q;
        if (flush || (!stall && !id_valid)) begin
            valid_d      = 1'b0;
            alu_result_d = {DATA_WIDTH{1'b0}};
            store_data_d = {DATA_WIDTH{1'b0}};
            rd_addr_d    = 5'd0;
            reg_write_d  = 1'b0;
            is_store_d   = 1'b0;
            instr_d      = NOP_INSTR;
        end else if (!stall) begin
            valid_d      = 1'b1;
            alu_result_d = alu_res_s;
            store_data_d = rs2_fwd_s;
            rd_addr_d    = id_rd_addr;
            reg_write_d  = id_reg_write;
            is_store_d   = id_is_store;
            instr_d      = id_instr;
        end else begin
            valid_d      = valid_q;
        end
    end

    // EX/MEM pipeline register with asynchronous reset to a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            alu_result_q <= {DATA_WIDTH{1'b0}};
            store_data_q <= {DATA_WIDTH{1'b0}};
            rd_addr_q    <= 5'd0;
            reg_write_q  <= 1'b0;
            is_store_q   <= 1'b0;
            instr_q      <= NOP_INSTR;
        end else begin
            valid_q      <= valid_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            rd_addr_q    <= rd_addr_d;
            reg_write_q  <= reg_write_d;
            is_store_q   <= is_store_d;
            instr_q      <= instr_d;
        end
    end

    assign ex_mem_valid      = valid_q;
    assign ex_mem_alu_result = alu_result_q;
    assign ex_mem_store_data = store_data_q;
    assign ex_mem_rd_addr    = rd_addr_q;
    assign ex_mem_reg_write  = reg_write_q;
    assign ex_mem_is_store   = is_store_q;
    assign ex_mem_instr      = instr_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus a randomized run
// against a behavioural model of the EX/MEM register.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_imm, id_is_store, id_reg_write;
    logic [4:0]  id_rd_addr;
    logic [31:0] id_instr;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        stall, flush;
    logic        ex_mem_valid;
    logic [31:0] ex_mem_alu_result, ex_mem_store_data;
    logic [4:0]  ex_mem_rd_addr;
    logic        ex_mem_reg_write, ex_mem_is_store;
    logic [31:0] ex_mem_instr;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .id_alu_op(id_alu_op),
        .id_alu_src_imm(id_alu_src_imm), .id_is_store(id_is_store),
        .id_reg_write(id_reg_write), .id_rd_addr(id_rd_addr), .id_instr(id_instr),
        .forward_a(forward_a), .forward_b(forward_b),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .stall(stall), .flush(flush),
        .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_store_data(ex_mem_store_data), .ex_mem_rd_addr(ex_mem_rd_addr),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_is_store(ex_mem_is_store),
        .ex_mem_instr(ex_mem_instr)
    );

    always #5 clk = ~clk;

    // Bundle of all outputs, in a fixed order, for whole-register comparisons.
    function automatic logic [103:0] outs();
        return {ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd_addr,
                ex_mem_reg_write, ex_mem_is_store, ex_mem_instr};
    endfunction

    function automatic logic [103:0] bubble();
        return {1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, NOP};
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                         input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return rf;
    endfunction

    // Reference ALU from the operation definitions, using 32-bit wraparound arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc);
        int unsigned sh;
        logic [31:0] r;
        sh = b % 32;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a * (32'd1 << sh);
            4'd3:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd4:  r = (a < b) ? 32'd1 : 32'd0;
            4'd5:  r = (a | b) & ~(a & b);
            4'd6:  r = a / (32'd1 << sh);
            4'd7:  begin
                r = a / (32'd1 << sh);
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'd8:  r = a | b;
            4'd9:  r = a & b;
            4'd10: r = b;
            4'd11: r = pc + b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
        id_pc = 32'd0; id_alu_op = 4'd0; id_alu_src_imm = 1'b0; id_is_store = 1'b0;
        id_reg_write = 1'b0; id_rd_addr = 5'd0; id_instr = 32'd0;
        forward_a = 2'd0; forward_b = 2'd0; mem_fwd_data = 32'd0; wb_fwd_data = 32'd0;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] instr);
        id_valid = 1'b1; id_alu_op = op; id_rs1_data = a; id_rs2_data = b;
        id_alu_src_imm = 1'b0; forward_a = 2'd0; forward_b = 2'd0;
        id_reg_write = 1'b1; id_rd_addr = 5'd7; id_instr = instr; id_is_store = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if (outs() !== bubble()) $display("FAIL reset_initial got=%h exp=%h", outs(), bubble());
        else n_pass++;
        set_alu(4'd0, 32'd1, 32'd2, 32'h0020_8033);
        @(posedge clk); #1;
        n_total++;
        if (outs() !== {1'b1, 32'd3, 32'd2, 5'd7, 1'b1, 1'b0, 32'h0020_8033})
            $display("FAIL reset_preload got=%h", outs());
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (outs() !== bubble()) $display("FAIL reset_async got=%h exp=%h", outs(), bubble());
        else n_pass++;
        #1 rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        logic [31:0] exp_a [4];
        exp_a[0] = 32'd12; exp_a[1] = 32'd207; exp_a[2] = 32'd107; exp_a[3] = 32'd12;
        for (int i = 0; i < 4; i++) begin
            set_alu(4'd0, 32'd5, 32'd7, 32'h1000 + i);
            mem_fwd_data = 32'd100; wb_fwd_data = 32'd200; forward_a = i[1:0];
            @(posedge clk); #1;
            n_total++;
            if (ex_mem_alu_result !== exp_a[i])
                $display("FAIL fwd_a_%0d got=%0d exp=%0d", i, ex_mem_alu_result, exp_a[i]);
            else n_pass++;
        end
        forward_a = 2'd0; forward_b = 2'd2;
        @(posedge clk); #1;
        n_total++;
        if (ex_mem_alu_result !== 32'd105 || ex_mem_store_data !== 32'd100)
            $display("FAIL fwd_b got=%0d/%0d exp=105/100", ex_mem_alu_result, ex_mem_store_data);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_store_data();
        set_alu(4'd0, 32'h1000, 32'd0, 32'h0080_A023);
        id_is_store = 1'b1; id_reg_write = 1'b0; id_alu_src_imm = 1'b1; id_imm = 32'd8;
        forward_b = 2'd1; wb_fwd_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        n_total++;
        if (ex_mem_alu_result !== 32'h1008 || ex_mem_store_data !== 32'hDEAD_BEEF ||
            ex_mem_is_store !== 1'b1 || ex_mem_reg_write !== 1'b0)
            $display("FAIL store_data got=%h/%h st=%b exp=00001008/deadbeef st=1",
                     ex_mem_alu_result, ex_mem_store_data, ex_mem_is_store);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_alu_edges();
        logic [3:0]  ops [6];
        logic [31:0] av [6], bv [6], ev [6];
        ops[0] = 4'd1;  av[0] = 32'd0;          bv[0] = 32'd1;  ev[0] = 32'hFFFF_FFFF;
        ops[1] = 4'd3;  av[1] = 32'hFFFF_FFFF;  bv[1] = 32'd1;  ev[1] = 32'd1;
        ops[2] = 4'd4;  av[2] = 32'hFFFF_FFFF;  bv[2] = 32'd1;  ev[2] = 32'd0;
        ops[3] = 4'd7;  av[3] = 32'h8000_0000;  bv[3] = 32'h24; ev[3] = 32'hF800_0000;
        ops[4] = 4'd6;  av[4] = 32'h8000_0000;  bv[4] = 32'h24; ev[4] = 32'h0800_0000;
        ops[5] = 4'd13; av[5] = 32'd5;          bv[5] = 32'd6;  ev[5] = 32'd0;
        for (int i = 0; i < 6; i++) begin
            set_alu(ops[i], av[i], bv[i], 32'h2000 + i);
            @(posedge clk); #1;
            n_total++;
            if (ex_mem_alu_result !== ev[i])
                $display("FAIL alu_op%0d got=%h exp=%h", ops[i], ex_mem_alu_result, ev[i]);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_stall_flush();
        set_alu(4'd0, 32'd1, 32'd2, 32'h3000);
        @(posedge clk); #1;
        set_alu(4'd0, 32'd10, 32'd20, 32'h3001);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (ex_mem_alu_result !== 32'd3 || ex_mem_valid !== 1'b1 || ex_mem_instr !== 32'h3000)
                $display("FAIL stall_hold%0d got=%0d exp=3", i, ex_mem_alu_result);
            else n_pass++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (outs() !== bubble()) $display("FAIL stall_flush got=%h exp=%h", outs(), bubble());
        else n_pass++;
        stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (outs() !== bubble()) $display("FAIL bubble_persist got=%h exp=%h", outs(), bubble());
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r [4];
        exp_r[0] = 32'h1040; exp_r[1] = 32'h1234_5000; exp_r[2] = 32'hFF00; exp_r[3] = 32'h00F0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin set_alu(4'd11, 32'd0, 32'd0, 32'h0000_1017);
                         id_alu_src_imm = 1'b1; id_imm = 32'h1000; id_pc = 32'h40; end
                1: begin set_alu(4'd10, 32'd0, 32'd0, 32'h1234_50B7);
                         id_alu_src_imm = 1'b1; id_imm = 32'h1234_5000; end
                2: set_alu(4'd5, 32'hF0F0, 32'h0FF0, 32'h0020_C133);
                default: set_alu(4'd9, 32'hF0F0, 32'h0FF0, 32'h0020_F1B3);
            endcase
            id_rd_addr = 5'(i + 1);
            @(posedge clk); #1;
            n_total++;
            if (ex_mem_alu_result !== exp_r[i] || ex_mem_instr !== id_instr ||
                ex_mem_rd_addr !== 5'(i + 1) || ex_mem_valid !== 1'b1)
                $display("FAIL b2b_%0d got=%h/%h exp=%h/%h", i, ex_mem_alu_result,
                         ex_mem_instr, exp_r[i], id_instr);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [103:0] model;
        logic [31:0]  a, b, rs2;
        model = outs();
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 5) != 0);
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_pc = $urandom; id_alu_op = 4'($urandom_range(0, 15));
            id_alu_src_imm = 1'($urandom); id_is_store = 1'($urandom);
            id_reg_write = 1'($urandom); id_rd_addr = 5'($urandom); id_instr = $urandom;
            forward_a = 2'($urandom); forward_b = 2'($urandom);
            mem_fwd_data = $urandom; wb_fwd_data = $urandom;
            stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 9) == 0);
            if (flush) model = bubble();
            else if (stall) model = model;
            else if (!id_valid) model = bubble();
            else begin
                a   = pick(forward_a, id_rs1_data, wb_fwd_data, mem_fwd_data);
                rs2 = pick(forward_b, id_rs2_data, wb_fwd_data, mem_fwd_data);
                b   = id_alu_src_imm ? id_imm : rs2;
                model = {1'b1, ref_alu(id_alu_op, a, b, id_pc), rs2, id_rd_addr,
                         id_reg_write, id_is_store, id_instr};
            end
            @(posedge clk); #1;
            n_total++;
            if (outs() !== model) $display("FAIL random_%0d got=%h exp=%h", i, outs(), model);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_forward();
        test_store_data();
        test_alu_edges();
        test_stall_flush();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
